// File: rtl/memory_pkg.sv
// Shared memory-access encodings and FSM states.
// Used by ram_io and by the CPU core load/store path.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        DONE
    } state_e;

    localparam logic [2:0] RT_NONE = 3'd0;
    localparam logic [2:0] RT_LB   = 3'd1;
    localparam logic [2:0] RT_LH   = 3'd2;
    localparam logic [2:0] RT_LW   = 3'd3;
    localparam logic [2:0] RT_LBU  = 3'd5;
    localparam logic [2:0] RT_LHU  = 3'd6;

    localparam logic [1:0] WT_NONE = 2'd0;
    localparam logic [1:0] WT_SB   = 2'd1;
    localparam logic [1:0] WT_SH   = 2'd2;
    localparam logic [1:0] WT_SW   = 2'd3;

    function automatic logic legal_read(input logic [2:0] rt);
        return (rt != 3'd4) && (rt != 3'd7);
    endfunction

    function automatic logic misaligned(
        input logic [2:0] rt,
        input logic [1:0] wt,
        input logic [1:0] off
    );
        logic half;
        logic word;
        half = (rt == RT_LH) || (rt == RT_LHU) || (wt == WT_SH);
        word = (rt == RT_LW) || (wt == WT_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_mask(
        input logic [1:0] wt,
        input logic [1:0] off
    );
        case (wt)
            WT_SB:   return 4'b0001 << off;
            WT_SH:   return 4'b0011 << off;
            WT_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(
        input logic [1:0]  wt,
        input logic [31:0] d
    );
        case (wt)
            WT_SB:   return {4{d[7:0]}};
            WT_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/ram_io_extend.sv
// Load lane selection and sign/zero extension.
// Purely combinational.
module ram_io_extend
    import memory_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_read_type,
    output logic [31:0] o_result
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_word >> {i_offset, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_shift[15:0];

    always_comb begin
        o_result = 32'h0;
        case (i_read_type)
            RT_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            RT_LBU:  o_result = {24'h0, w_byte};
            RT_LH:   o_result = {{16{w_half[15]}}, w_half};
            RT_LHU:  o_result = {16'h0, w_half};
            RT_LW:   o_result = i_word;
            default: o_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/ram_io.sv
// CPU-side load/store front end to the data cache,
// with a memory-mapped LED register.
module ram_io
    import memory_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH = 32,
    parameter logic [ADDRESS_BITWIDTH-1:0] LED_ADDRESS = 32'hFFFF_FFFC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    input  logic [2:0]                  read_type,
    input  logic [1:0]                  write_type,
    input  logic [31:0]                 data_in,
    output logic [31:0]                 data_out,
    output logic                        data_out_ready,
    output logic                        busy,
    output logic                        error,
    output logic [3:0]                  led,
    output logic [ADDRESS_BITWIDTH-1:0] c_address,
    output logic [31:0]                 c_data_in,
    output logic [3:0]                  c_write_enable,
    input  logic [31:0]                 c_data_out,
    input  logic                        c_data_out_ready,
    input  logic                        c_busy
);

    state_e                      r_state;
    logic [2:0]                  r_read_type;
    logic [1:0]                  r_offset;
    logic [31:0]                 r_data_out;
    logic                        r_ready;
    logic                        r_busy;
    logic                        r_error;
    logic [3:0]                  r_led;
    logic [ADDRESS_BITWIDTH-1:0] r_c_address;
    logic [31:0]                 r_c_data_in;
    logic [3:0]                  r_c_we;

    logic        w_rd;
    logic        w_wr;
    logic        w_bad;
    logic        w_led;
    logic [31:0] w_ext;

    assign w_rd  = (read_type != RT_NONE);
    assign w_wr  = (write_type != WT_NONE);
    assign w_led = (address == LED_ADDRESS);
    assign w_bad = (w_rd && w_wr) || !legal_read(read_type)
                || misaligned(read_type, write_type, address[1:0]);

    ram_io_extend u_extend (
        .i_word      (c_data_out),
        .i_offset    (r_offset),
        .i_read_type (r_read_type),
        .o_result    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_read_type <= RT_NONE;
            r_offset    <= 2'b00;
            r_data_out  <= 32'h0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_led       <= 4'h0;
            r_c_address <= '0;
            r_c_data_in <= 32'h0;
            r_c_we      <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && w_bad) begin
                        r_error <= 1'b1;
                    end else if (enable && w_led && (w_rd || w_wr)) begin
                        // LED register answers in one cycle, cache untouched
                        if (w_wr) r_led <= data_in[3:0];
                        else      r_data_out <= {28'h0, r_led};
                        r_ready <= w_rd;
                        r_state <= DONE;
                    end else if (enable && (w_rd || w_wr)) begin
                        r_read_type <= read_type;
                        r_offset    <= address[1:0];
                        r_c_address <= {address[ADDRESS_BITWIDTH-1:2], 2'b00};
                        r_busy      <= 1'b1;
                        if (w_wr) begin
                            r_c_we      <= store_mask(write_type, address[1:0]);
                            r_c_data_in <= store_data(write_type, data_in);
                            r_state     <= WRITE_WAIT;
                        end else begin
                            r_state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (c_data_out_ready && !c_busy) begin
                        r_data_out <= w_ext;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                WRITE_WAIT: begin
                    // strobe lasts one accepted cycle, then wait for idle cache
                    if (!c_busy) begin
                        if (r_c_we != 4'h0) begin
                            r_c_we <= 4'h0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_out_ready = r_ready;
    assign busy           = r_busy;
    assign error          = r_error;
    assign led            = r_led;
    assign c_address      = r_c_address;
    assign c_data_in      = r_c_data_in;
    assign c_write_enable = r_c_we;

endmodule

// File: tb/tb_ram_io.sv
// Directed-vector bench for ram_io with a small behavioural cache stub.
module tb_ram_io;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] address = 32'h0;
    logic [2:0]  read_type = 3'd0;
    logic [1:0]  write_type = 2'd0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        error;
    logic [3:0]  led;
    logic [31:0] c_address;
    logic [31:0] c_data_in;
    logic [3:0]  c_write_enable;
    logic [31:0] c_data_out;
    logic        c_data_out_ready;
    logic        c_busy;

    logic        tb_cbusy = 1'b0;
    logic [31:0] mem [0:31];
    int          rdy_cnt = 0;
    int          we_cnt = 0;
    logic [3:0]  last_we = 4'h0;
    logic [31:0] last_cdi = 32'h0;
    int          n_vec = 0;
    int          n_bad = 0;

    ram_io dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .read_type        (read_type),
        .write_type       (write_type),
        .data_in          (data_in),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .busy             (busy),
        .error            (error),
        .led              (led),
        .c_address        (c_address),
        .c_data_in        (c_data_in),
        .c_write_enable   (c_write_enable),
        .c_data_out       (c_data_out),
        .c_data_out_ready (c_data_out_ready),
        .c_busy           (c_busy)
    );

    always #5 clk = ~clk;

    assign c_busy           = tb_cbusy;
    assign c_data_out_ready = !tb_cbusy;
    assign c_data_out       = mem[c_address[6:2]];

    always @(posedge clk) begin
        if (data_out_ready) rdy_cnt++;
        if (c_write_enable != 4'h0) begin
            we_cnt++;
            last_we  = c_write_enable;
            last_cdi = c_data_in;
            if (!tb_cbusy) begin
                for (int b = 0; b < 4; b++)
                    if (c_write_enable[b])
                        mem[c_address[6:2]][b*8 +: 8] = c_data_in[b*8 +: 8];
            end
        end
    end

    task automatic run_req(input logic [31:0] a, input logic [2:0] rt,
                           input logic [1:0] wt, input logic [31:0] d);
        int k;
        @(negedge clk);
        rdy_cnt = 0;
        we_cnt = 0;
        address = a;
        read_type = rt;
        write_type = wt;
        data_in = d;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_timeout: busy still %b after %0d cycles, want 0", busy, k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, data_out_ready, error, led, c_write_enable} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %h want 000", {busy, data_out_ready, error, led, c_write_enable});
        end
        n_vec++;
        if ({data_out, c_address, c_data_in} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {data_out, c_address, c_data_in});
        end
        rst = 1'b0;
    endtask

    task automatic test_loads;
        logic [31:0] exp_d [5];
        logic [31:0] addr [5];
        logic [2:0]  rts [5];
        addr[0] = 32'd11; rts[0] = 3'd1; exp_d[0] = 32'hFFFF_FFAB;
        addr[1] = 32'd11; rts[1] = 3'd5; exp_d[1] = 32'h0000_00AB;
        addr[2] = 32'd8;  rts[2] = 3'd2; exp_d[2] = 32'h0000_3E6F;
        addr[3] = 32'd10; rts[3] = 3'd6; exp_d[3] = 32'h0000_AB4C;
        addr[4] = 32'd8;  rts[4] = 3'd3; exp_d[4] = 32'hAB4C_3E6F;
        for (int i = 0; i < 5; i++) begin
            run_req(addr[i], rts[i], 2'd0, 32'h0);
            n_vec++;
            if (data_out !== exp_d[i]) begin
                n_bad++;
                $display("FAIL load%0d_data: got %h want %h", i, data_out, exp_d[i]);
            end
            n_vec++;
            if (rdy_cnt !== 1 || we_cnt !== 0) begin
                n_bad++;
                $display("FAIL load%0d_pulses: rdy %0d we %0d want 1 0", i, rdy_cnt, we_cnt);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] ca;
        ca = c_address;
        run_req(32'd9, 3'd2, 2'd0, 32'h0);
        n_vec++;
        if (error !== 1'b1 || c_address !== ca || rdy_cnt !== 0) begin
            n_bad++;
            $display("FAIL lh_misaligned: err %b caddr %h rdy %0d want 1 %h 0", error, c_address, rdy_cnt, ca);
        end
        n_vec++;
        if (data_out !== 32'hAB4C_3E6F) begin
            n_bad++;
            $display("FAIL data_hold: got %h want ab4c3e6f", data_out);
        end
        run_req(32'd4, 3'd3, 2'd3, 32'h0);
        n_vec++;
        if (error !== 1'b1 || c_address !== ca || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL both_types: err %b caddr %h we %0d want 1 %h 0", error, c_address, we_cnt, ca);
        end
    endtask

    task automatic test_stores;
        run_req(32'd9, 3'd0, 2'd1, 32'h0000_0012);
        n_vec++;
        if (last_we !== 4'b0010 || we_cnt !== 1 || last_cdi !== 32'h1212_1212 || rdy_cnt !== 0) begin
            n_bad++;
            $display("FAIL sb: we %b x%0d cdi %h rdy %0d want 0010 x1 12121212 0", last_we, we_cnt, last_cdi, rdy_cnt);
        end
        run_req(32'd8, 3'd3, 2'd0, 32'h0);
        n_vec++;
        if (data_out !== 32'hAB4C_126F) begin
            n_bad++;
            $display("FAIL sb_readback: got %h want ab4c126f", data_out);
        end
        run_req(32'd2, 3'd0, 2'd2, 32'h0000_BEEF);
        n_vec++;
        if (last_we !== 4'b1100 || we_cnt !== 1 || last_cdi !== 32'hBEEF_BEEF) begin
            n_bad++;
            $display("FAIL sh: we %b x%0d cdi %h want 1100 x1 beefbeef", last_we, we_cnt, last_cdi);
        end
        run_req(32'd0, 3'd3, 2'd0, 32'h0);
        n_vec++;
        if (data_out !== 32'hBEEF_3344) begin
            n_bad++;
            $display("FAIL sh_readback: got %h want beef3344", data_out);
        end
        run_req(32'd4, 3'd0, 2'd3, 32'h89AB_CDEF);
        n_vec++;
        if (last_we !== 4'b1111 || last_cdi !== 32'h89AB_CDEF || mem[1] !== 32'h89AB_CDEF) begin
            n_bad++;
            $display("FAIL sw: we %b cdi %h mem %h want 1111 89abcdef", last_we, last_cdi, mem[1]);
        end
    endtask

    task automatic test_miss;
        int bad_busy;
        int bad_addr;
        int k;
        bad_busy = 0;
        bad_addr = 0;
        @(negedge clk);
        tb_cbusy = 1'b1;
        rdy_cnt = 0;
        address = 32'd64;
        read_type = 3'd3;
        write_type = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) bad_busy++;
            if (c_address !== 32'd64) bad_addr++;
            enable = (i % 2 == 0);
            address = 32'd8;
            @(negedge clk);
        end
        enable = 1'b0;
        tb_cbusy = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bad_busy != 0 || bad_addr != 0 || k >= 50) begin
            n_bad++;
            $display("FAIL miss_hold: busy drops %0d addr changes %0d wait %0d want 0 0 <50", bad_busy, bad_addr, k);
        end
        n_vec++;
        if (data_out !== 32'hCAFE_F00D || rdy_cnt !== 1) begin
            n_bad++;
            $display("FAIL miss_data: got %h rdy %0d want cafef00d 1", data_out, rdy_cnt);
        end
    endtask

    task automatic test_led;
        logic [31:0] ca;
        ca = c_address;
        run_req(32'hFFFF_FFFC, 3'd0, 2'd3, 32'h0000_0005);
        n_vec++;
        if (led !== 4'b0101 || we_cnt !== 0 || c_address !== ca || rdy_cnt !== 0) begin
            n_bad++;
            $display("FAIL led_write: led %b we %0d caddr %h rdy %0d want 0101 0 %h 0", led, we_cnt, c_address, rdy_cnt, ca);
        end
        run_req(32'hFFFF_FFFC, 3'd3, 2'd0, 32'h0);
        n_vec++;
        if (data_out !== 32'h5 || rdy_cnt !== 1 || c_address !== ca) begin
            n_bad++;
            $display("FAIL led_read: got %h rdy %0d caddr %h want 5 1 %h", data_out, rdy_cnt, c_address, ca);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        tb_cbusy = 1'b1;
        we_cnt = 0;
        address = 32'd8;
        read_type = 3'd3;
        write_type = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, data_out_ready, error, led, c_write_enable} !== 11'h0
            || {data_out, c_address, c_data_in} !== 96'h0) begin
            n_bad++;
            $display("FAIL mid_reset: ctl %h data %h want 0 0",
                     {busy, data_out_ready, error, led, c_write_enable}, {data_out, c_address, c_data_in});
        end
        tb_cbusy = 1'b0;
        run_req(32'd8, 3'd3, 2'd0, 32'h0);
        n_vec++;
        if (data_out !== 32'hAB4C_126F || rdy_cnt !== 1 || we_cnt !== 0) begin
            n_bad++;
            $display("FAIL post_reset_lw: got %h rdy %0d we %0d want ab4c126f 1 0", data_out, rdy_cnt, we_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'h1122_3344;
        mem[2]  = 32'hAB4C_3E6F;
        mem[16] = 32'hCAFE_F00D;
        test_reset;
        test_loads;
        test_errors;
        test_stores;
        test_miss;
        test_led;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
